// File: rtl/dice_turn_controller.sv
// -----------------------------------------------------------------------------
// dice_turn_controller
//
// Turn-based dice race for 2..4 players. Consumes the colour detector's result
// interface, arms on a white background, accepts one dice colour per turn,
// maps the colour to a step count and animates the current player's token
// one square per STEP_CYCLES clocks. The background must return to white
// before the turn passes. The first token to reach the last square wins.
//
// Ports:
//   clk                 in   system clock
//   reset               in   asynchronous, active-high
//   start_btn           in   debounced level; rising edge starts/restarts game
//   stable_color        in   00=NONE 01=RED 10=GREEN 11=BLUE
//   result_ready        in   one-cycle pulse, stable_color valid
//   current_state_white in   level, white background present
//   cur_player          out  player whose turn it is
//   positions           out  packed lanes, lane i = player i (unused lanes 0)
//   last_roll           out  colour of the most recently accepted roll
//   moving              out  high while the token is being animated
//   turn_done           out  one-cycle pulse when the turn passes on
//   winner_valid        out  level, game over
//   winner_id           out  winning player, valid with winner_valid
//   fsm_state           out  debug state encoding
// -----------------------------------------------------------------------------
module dice_turn_controller #(
  parameter int          NUM_PLAYERS = 2,
  parameter int          BOARD_LEN   = 20,
  parameter int          POS_W       = 5,
  parameter logic [2:0]  STEPS_RED   = 3'd1,
  parameter logic [2:0]  STEPS_GREEN = 3'd2,
  parameter logic [2:0]  STEPS_BLUE  = 3'd3,
  parameter logic [24:0] STEP_CYCLES = 25'd12_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic [1:0]         stable_color,
  input  logic               result_ready,
  input  logic               current_state_white,
  output logic [1:0]         cur_player,
  output logic [4*POS_W-1:0] positions,
  output logic [1:0]         last_roll,
  output logic               moving,
  output logic               turn_done,
  output logic               winner_valid,
  output logic [1:0]         winner_id,
  output logic [2:0]         fsm_state
);

  localparam int TIMER_W = (STEP_CYCLES > 25'd1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(STEP_CYCLES - 25'd1);
  localparam logic [POS_W-1:0]   FINISH_POS   = POS_W'(BOARD_LEN - 1);
  localparam logic [1:0]         LAST_PLAYER  = 2'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ARM        = 3'd1,
    S_WAIT_DICE  = 3'd2,
    S_MOVE       = 3'd3,
    S_WAIT_CLEAR = 3'd4,
    S_NEXT       = 3'd5,
    S_GAME_OVER  = 3'd6
  } state_t;

  // Registered state
  state_t                 r_state;
  logic                   r_start_q;
  logic [3:0][POS_W-1:0]  r_pos;
  logic [1:0]             r_cur_player;
  logic [1:0]             r_last_roll;
  logic [2:0]             r_steps;
  logic [TIMER_W-1:0]     r_timer;
  logic                   r_moving;
  logic                   r_turn_done;
  logic                   r_winner_valid;
  logic [1:0]             r_winner_id;

  // Next-state values
  state_t                 w_state_next;
  logic [3:0][POS_W-1:0]  w_pos_next;
  logic [1:0]             w_cur_player_next;
  logic [1:0]             w_last_roll_next;
  logic [2:0]             w_steps_next;
  logic [TIMER_W-1:0]     w_timer_next;
  logic                   w_turn_done_next;
  logic                   w_winner_valid_next;
  logic [1:0]             w_winner_id_next;

  logic                   w_start_edge;
  logic [2:0]             w_roll_steps;
  logic [POS_W-1:0]       w_pos_inc;

  assign w_start_edge = start_btn & ~r_start_q;
  assign w_pos_inc    = r_pos[r_cur_player] + POS_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_roll_steps = 3'd0;
    case (stable_color)
      2'b01:   w_roll_steps = STEPS_RED;
      2'b10:   w_roll_steps = STEPS_GREEN;
      2'b11:   w_roll_steps = STEPS_BLUE;
      default: w_roll_steps = 3'd0;
    endcase
  end

  always_comb begin
    w_state_next        = r_state;
    w_pos_next          = r_pos;
    w_cur_player_next   = r_cur_player;
    w_last_roll_next    = r_last_roll;
    w_steps_next        = r_steps;
    w_timer_next        = r_timer;
    w_turn_done_next    = 1'b0;
    w_winner_valid_next = r_winner_valid;
    w_winner_id_next    = r_winner_id;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) w_state_next = S_ARM;
      end

      // Dice results seen before the board is white are stale and dropped.
      S_ARM: begin
        if (current_state_white) w_state_next = S_WAIT_DICE;
      end

      S_WAIT_DICE: begin
        if (result_ready && (stable_color != 2'b00)) begin
          w_last_roll_next = stable_color;
          w_steps_next     = w_roll_steps;
          w_timer_next     = TIMER_RELOAD;
          w_state_next     = S_MOVE;
        end
      end

      // The timer is loaded with STEP_CYCLES-1 on entry, so the first square
      // is taken exactly STEP_CYCLES clocks after MOVE begins.
      S_MOVE: begin
        if (r_timer == '0) begin
          w_timer_next                 = TIMER_RELOAD;
          w_pos_next[r_cur_player]     = w_pos_inc;
          w_steps_next                 = r_steps - 3'd1;
          if (w_pos_inc == FINISH_POS) begin
            // Remaining steps are discarded; the token stops on the finish.
            w_state_next        = S_GAME_OVER;
            w_winner_valid_next = 1'b1;
            w_winner_id_next    = r_cur_player;
          end else if (r_steps == 3'd1) begin
            w_state_next = S_WAIT_CLEAR;
          end
        end else begin
          w_timer_next = r_timer - TIMER_W'(1);
        end
      end

      // The turn advances on entry to NEXT so cur_player and turn_done are
      // presented together during the NEXT cycle.
      S_WAIT_CLEAR: begin
        if (current_state_white) begin
          w_state_next      = S_NEXT;
          w_turn_done_next  = 1'b1;
          w_cur_player_next = (r_cur_player == LAST_PLAYER) ? 2'd0
                                                            : r_cur_player + 2'd1;
        end
      end

      S_NEXT: begin
        w_state_next = S_WAIT_DICE;
      end

      S_GAME_OVER: begin
        w_state_next = S_GAME_OVER;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Restart overrides whatever the state decode chose this cycle.
    if (w_start_edge && (r_state != S_IDLE)) begin
      w_state_next        = S_ARM;
      w_pos_next          = '0;
      w_cur_player_next   = 2'd0;
      w_last_roll_next    = 2'd0;
      w_steps_next        = 3'd0;
      w_timer_next        = '0;
      w_turn_done_next    = 1'b0;
      w_winner_valid_next = 1'b0;
      w_winner_id_next    = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_start_q      <= 1'b0;
      r_pos          <= '0;
      r_cur_player   <= 2'd0;
      r_last_roll    <= 2'd0;
      r_steps        <= 3'd0;
      r_timer        <= '0;
      r_moving       <= 1'b0;
      r_turn_done    <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner_id    <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // of the previous cycle regardless of statement order.
      r_state        <= w_state_next;
      r_start_q      <= start_btn;
      r_pos          <= w_pos_next;
      r_cur_player   <= w_cur_player_next;
      r_last_roll    <= w_last_roll_next;
      r_steps        <= w_steps_next;
      r_timer        <= w_timer_next;
      r_moving       <= (w_state_next == S_MOVE);
      r_turn_done    <= w_turn_done_next;
      r_winner_valid <= w_winner_valid_next;
      r_winner_id    <= w_winner_id_next;
    end
  end

  assign cur_player   = r_cur_player;
  assign positions    = r_pos;
  assign last_roll    = r_last_roll;
  assign moving       = r_moving;
  assign turn_done    = r_turn_done;
  assign winner_valid = r_winner_valid;
  assign winner_id    = r_winner_id;
  assign fsm_state    = r_state;

endmodule

// File: tb/tb_dice_turn_controller.sv
// -----------------------------------------------------------------------------
// tb_dice_turn_controller
//
// Directed bench for dice_turn_controller with STEP_CYCLES=4, BOARD_LEN=20.
// A 2-player instance carries most scenarios; a 3-player instance shares the
// same stimulus and is inspected for turn rotation and unused-lane behaviour.
// -----------------------------------------------------------------------------
module tb_dice_turn_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic [1:0]  color;
  logic        result_ready;
  logic        white;

  logic [1:0]  cur_player, last_roll, winner_id;
  logic [19:0] positions;
  logic        moving, turn_done, winner_valid;
  logic [2:0]  fsm_state;

  logic [1:0]  t3_cur_player, t3_last_roll, t3_winner_id;
  logic [19:0] t3_positions;
  logic        t3_moving, t3_turn_done, t3_winner_valid;
  logic [2:0]  t3_fsm_state;

  int checks = 0;
  int errors = 0;
  int exp_pos[2];
  int exp_cur;

  dice_turn_controller #(
    .NUM_PLAYERS(2), .BOARD_LEN(20), .POS_W(5), .STEP_CYCLES(25'd4)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stable_color(color),
    .result_ready(result_ready), .current_state_white(white),
    .cur_player(cur_player), .positions(positions), .last_roll(last_roll),
    .moving(moving), .turn_done(turn_done), .winner_valid(winner_valid),
    .winner_id(winner_id), .fsm_state(fsm_state)
  );

  dice_turn_controller #(
    .NUM_PLAYERS(3), .BOARD_LEN(20), .POS_W(5), .STEP_CYCLES(25'd4)
  ) dut3 (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stable_color(color),
    .result_ready(result_ready), .current_state_white(white),
    .cur_player(t3_cur_player), .positions(t3_positions), .last_roll(t3_last_roll),
    .moving(t3_moving), .turn_done(t3_turn_done), .winner_valid(t3_winner_valid),
    .winner_id(t3_winner_id), .fsm_state(t3_fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] exp_vec();
    return 20'(exp_pos[0]) | (20'(exp_pos[1]) << 5);
  endfunction

  task automatic test_reset();
    reset = 1'b1; start_btn = 1'b0; color = 2'b00; result_ready = 1'b0; white = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", fsm_state); end
    checks++; if (positions !== 20'd0) begin errors++; $display("FAIL reset_positions got %h want 0", positions); end
    checks++; if ({cur_player, last_roll, winner_id} !== 6'd0) begin errors++; $display("FAIL reset_ids got %b want 0", {cur_player, last_roll, winner_id}); end
    checks++; if ({moving, turn_done, winner_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {moving, turn_done, winner_valid}); end
    // Dice result while idle must do nothing.
    color = 2'b11; result_ready = 1'b1; tick(); result_ready = 1'b0;
    checks++; if ({fsm_state, last_roll} !== {3'd0, 2'd0}) begin errors++; $display("FAIL idle_ignore got st=%0d roll=%0d want st=0 roll=0", fsm_state, last_roll); end
  endtask

  task automatic test_basic_turn();
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    checks++; if (fsm_state !== 3'd1) begin errors++; $display("FAIL start_arm got %0d want 1", fsm_state); end
    color = 2'b01; result_ready = 1'b1; tick(); result_ready = 1'b0;
    checks++; if ({fsm_state, last_roll} !== {3'd1, 2'd0}) begin errors++; $display("FAIL arm_ignore got st=%0d roll=%0d want st=1 roll=0", fsm_state, last_roll); end
    white = 1'b1; tick(); white = 1'b0;
    checks++; if (fsm_state !== 3'd2) begin errors++; $display("FAIL arm_to_wait got %0d want 2", fsm_state); end
    color = 2'b11; result_ready = 1'b1; tick(); result_ready = 1'b0;
    checks++; if ({fsm_state, moving, last_roll} !== {3'd3, 1'b1, 2'd3}) begin errors++; $display("FAIL enter_move got st=%0d mv=%0d roll=%0d want st=3 mv=1 roll=3", fsm_state, moving, last_roll); end
    for (int s = 1; s <= 3; s++) begin
      if (s == 2) begin color = 2'b01; result_ready = 1'b1; end
      tick();
      result_ready = 1'b0;
      repeat (2) tick();
      checks++; if (positions !== 20'(s - 1)) begin errors++; $display("FAIL step%0d_early got %0d want %0d", s, positions, s - 1); end
      tick();
      checks++; if (positions !== 20'(s)) begin errors++; $display("FAIL step%0d_pos got %0d want %0d", s, positions, s); end
    end
    checks++; if ({fsm_state, moving, last_roll} !== {3'd4, 1'b0, 2'd3}) begin errors++; $display("FAIL to_wait_clear got st=%0d mv=%0d roll=%0d want st=4 mv=0 roll=3", fsm_state, moving, last_roll); end
    color = 2'b01; result_ready = 1'b1; tick(); result_ready = 1'b0;
    checks++; if ({fsm_state, positions} !== {3'd4, 20'd3}) begin errors++; $display("FAIL clear_ignore got st=%0d pos=%h want st=4 pos=3", fsm_state, positions); end
    white = 1'b1; tick(); white = 1'b0;
    checks++; if ({fsm_state, turn_done, cur_player} !== {3'd5, 1'b1, 2'd1}) begin errors++; $display("FAIL next got st=%0d td=%0d cp=%0d want st=5 td=1 cp=1", fsm_state, turn_done, cur_player); end
    tick();
    checks++; if ({fsm_state, turn_done} !== {3'd2, 1'b0}) begin errors++; $display("FAIL after_next got st=%0d td=%0d want st=2 td=0", fsm_state, turn_done); end
    exp_pos[0] = 3; exp_pos[1] = 0; exp_cur = 1;
  endtask

  task automatic test_none_color();
    color = 2'b00; result_ready = 1'b1; tick(); result_ready = 1'b0;
    tick();
    checks++; if ({fsm_state, moving, positions} !== {3'd2, 1'b0, exp_vec()}) begin errors++; $display("FAIL none_color got st=%0d mv=%0d pos=%h want st=2 mv=0 pos=%h", fsm_state, moving, positions, exp_vec()); end
  endtask

  // One complete non-winning turn for the 2-player instance.
  task automatic do_turn(input logic [1:0] c, input int steps);
    int n;
    color = c; result_ready = 1'b1; tick(); result_ready = 1'b0;
    n = 0;
    while (fsm_state == 3'd3 && n < 100) begin tick(); n++; end
    exp_pos[exp_cur] += steps;
    checks++; if ({fsm_state, positions} !== {3'd4, exp_vec()} || n != 4 * steps) begin errors++; $display("FAIL turn_move got st=%0d pos=%h cycles=%0d want st=4 pos=%h cycles=%0d", fsm_state, positions, n, exp_vec(), 4 * steps); end
    white = 1'b1; tick(); white = 1'b0;
    exp_cur = (exp_cur + 1) % 2;
    checks++; if ({fsm_state, turn_done, cur_player} !== {3'd5, 1'b1, 2'(exp_cur)}) begin errors++; $display("FAIL turn_next got st=%0d td=%0d cp=%0d want st=5 td=1 cp=%0d", fsm_state, turn_done, cur_player, exp_cur); end
    tick();
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 5; i++) begin
      do_turn(2'b01, 1);
      do_turn(2'b11, 3);
    end
    do_turn(2'b01, 1);
    checks++; if (positions !== {10'd0, 5'd6, 5'd18}) begin errors++; $display("FAIL pre_win_pos got %h want %h", positions, {10'd0, 5'd6, 5'd18}); end
    color = 2'b11; result_ready = 1'b1; tick(); result_ready = 1'b0;
    repeat (3) tick();
    checks++; if ({fsm_state, positions[4:0]} !== {3'd3, 5'd18}) begin errors++; $display("FAIL win_early got st=%0d p0=%0d want st=3 p0=18", fsm_state, positions[4:0]); end
    tick();
    checks++; if ({fsm_state, positions[4:0], moving} !== {3'd6, 5'd19, 1'b0}) begin errors++; $display("FAIL win_reach got st=%0d p0=%0d mv=%0d want st=6 p0=19 mv=0", fsm_state, positions[4:0], moving); end
    checks++; if ({winner_valid, winner_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL winner got v=%0d id=%0d want v=1 id=0", winner_valid, winner_id); end
    color = 2'b01; result_ready = 1'b1; white = 1'b1;
    repeat (12) tick();
    result_ready = 1'b0; white = 1'b0;
    checks++; if ({fsm_state, winner_valid, positions} !== {3'd6, 1'b1, 10'd0, 5'd6, 5'd19}) begin errors++; $display("FAIL game_over_hold got st=%0d wv=%0d pos=%h want st=6 wv=1 pos=%h", fsm_state, winner_valid, positions, {10'd0, 5'd6, 5'd19}); end
  endtask

  task automatic test_three_players();
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    checks++; if ({fsm_state, positions, cur_player, winner_valid, last_roll} !== {3'd1, 20'd0, 2'd0, 1'b0, 2'd0}) begin errors++; $display("FAIL restart_clear got st=%0d pos=%h cp=%0d wv=%0d roll=%0d want 1/0/0/0/0", fsm_state, positions, cur_player, winner_valid, last_roll); end
    checks++; if ({t3_fsm_state, t3_cur_player, t3_positions} !== {3'd1, 2'd0, 20'd0}) begin errors++; $display("FAIL p3_restart got st=%0d cp=%0d pos=%h want st=1 cp=0 pos=0", t3_fsm_state, t3_cur_player, t3_positions); end
    white = 1'b1; tick(); white = 1'b0;
    exp_pos[0] = 0; exp_pos[1] = 0; exp_cur = 0;
    for (int i = 0; i < 3; i++) begin
      do_turn(2'b01, 1);
      checks++; if (t3_cur_player !== 2'((i + 1) % 3)) begin errors++; $display("FAIL p3_rotation%0d got %0d want %0d", i, t3_cur_player, (i + 1) % 3); end
    end
    checks++; if (t3_positions !== 20'h00421) begin errors++; $display("FAIL p3_positions got %h want 00421", t3_positions); end
  endtask

  task automatic test_restart_on_expiry();
    color = 2'b11; result_ready = 1'b1; tick(); result_ready = 1'b0;
    repeat (3) tick();
    checks++; if ({fsm_state, positions} !== {3'd3, exp_vec()}) begin errors++; $display("FAIL pre_restart got st=%0d pos=%h want st=3 pos=%h", fsm_state, positions, exp_vec()); end
    start_btn = 1'b1; tick(); start_btn = 1'b0;
    checks++; if ({fsm_state, positions, cur_player, moving, last_roll} !== {3'd1, 20'd0, 2'd0, 1'b0, 2'd0}) begin errors++; $display("FAIL restart_expiry got st=%0d pos=%h cp=%0d mv=%0d roll=%0d want 1/0/0/0/0", fsm_state, positions, cur_player, moving, last_roll); end
    checks++; if ({t3_fsm_state, t3_positions} !== {3'd1, 20'd0}) begin errors++; $display("FAIL p3_restart_expiry got st=%0d pos=%h want st=1 pos=0", t3_fsm_state, t3_positions); end
  endtask

  task automatic test_async_reset();
    white = 1'b1; tick(); white = 1'b0;
    color = 2'b10; result_ready = 1'b1; tick(); result_ready = 1'b0;
    repeat (4) tick();
    checks++; if ({fsm_state, positions} !== {3'd3, 20'd1}) begin errors++; $display("FAIL pre_reset got st=%0d pos=%h want st=3 pos=1", fsm_state, positions); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({fsm_state, positions, cur_player, last_roll} !== {3'd0, 20'd0, 2'd0, 2'd0}) begin errors++; $display("FAIL async_reset got st=%0d pos=%h cp=%0d roll=%0d want all 0", fsm_state, positions, cur_player, last_roll); end
    checks++; if ({moving, turn_done, winner_valid, winner_id, t3_fsm_state} !== 8'd0) begin errors++; $display("FAIL async_reset_flags got %b want 0", {moving, turn_done, winner_valid, winner_id, t3_fsm_state}); end
    @(posedge clk); #1 reset = 1'b0;
    tick();
    checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL post_reset_idle got %0d want 0", fsm_state); end
  endtask

  initial begin
    test_reset();
    test_basic_turn();
    test_none_color();
    test_game_over();
    test_three_players();
    test_restart_on_expiry();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
